// File: rtl/bus_sequencer_if.sv
// Handshake and bus-control bundle between the instruction source and the bus_sequencer.
// The master modport is the instruction source. The slave modport is the sequencer, which drives the mux selects and load enables.
interface bus_sequencer_if;
    logic        run;
    logic [15:0] din;
    logic        g_zero;
    logic        imediate_select;
    logic        r0_select;
    logic        r1_select;
    logic        r2_select;
    logic        r3_select;
    logic        r4_select;
    logic        r5_select;
    logic        r6_select;
    logic        r7_select;
    logic        r_select;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        alu_sub;
    logic        busy;
    logic        done;

    modport master (
        output run, din, g_zero,
        input  imediate_select, r0_select, r1_select, r2_select, r3_select,
               r4_select, r5_select, r6_select, r7_select, r_select,
               r_in, a_in, g_in, alu_sub, busy, done
    );

    modport slave (
        input  run, din, g_zero,
        output imediate_select, r0_select, r1_select, r2_select, r3_select,
               r4_select, r5_select, r6_select, r7_select, r_select,
               r_in, a_in, g_in, alu_sub, busy, done
    );
endinterface

// File: rtl/bus_sequencer.sv
// Control sequencer for the 16-bit datapath. It runs one instruction per accepted run, over 1-3 execute cycles.
// Optional feature: define BUS_SEQ_MVNZ_EN to execute opcode 100 as mvnz (otherwise it is illegal).
module bus_sequencer (
    input  logic               clock,
    input  logic               reset,
    bus_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100
    } opcode_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [7:0]  w_rx_hot;
    logic [7:0]  w_ry_hot;

    logic        w_imm_sel;
    logic [7:0]  w_reg_sel;
    logic        w_g_sel;
    logic [7:0]  w_r_in;
    logic        w_a_in;
    logic        w_g_in;
    logic        w_alu_sub;
    logic        w_done;
    logic        w_unused;

    assign w_op     = r_ir[15:13];
    assign w_rx     = r_ir[12:10];
    assign w_ry     = r_ir[9:7];
    assign w_rx_hot = 8'b1 << w_rx;
    assign w_ry_hot = 8'b1 << w_ry;

    // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
    // NOTE: the async reset clears both registers, so the outputs (pure decodes of them) drop at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.run) begin
                r_ir <= bus.din;
            end
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next    = r_state;
        w_imm_sel = 1'b0;
        w_reg_sel = 8'h00;
        w_g_sel   = 1'b0;
        w_r_in    = 8'h00;
        w_a_in    = 1'b0;
        w_g_in    = 1'b0;
        w_alu_sub = 1'b0;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next = S_T1;
                end
            end
            S_T1: begin
                w_next = S_IDLE;
                case (w_op)
                    OP_MV: begin
                        w_reg_sel = w_ry_hot;
                        w_r_in    = w_rx_hot;
                        w_done    = 1'b1;
                    end
                    OP_MVI: begin
                        w_imm_sel = 1'b1;
                        w_r_in    = w_rx_hot;
                        w_done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_reg_sel = w_rx_hot;
                        w_a_in    = 1'b1;
                        w_next    = S_T2;
                    end
`ifdef BUS_SEQ_MVNZ_EN
                    OP_MVNZ: begin
                        if (!bus.g_zero) begin
                            w_reg_sel = w_ry_hot;
                            w_r_in    = w_rx_hot;
                        end
                        w_done = 1'b1;
                    end
`endif
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                w_reg_sel = w_ry_hot;
                w_g_in    = 1'b1;
                w_alu_sub = w_op[0];
                w_next    = S_T3;
            end
            S_T3: begin
                w_g_sel = 1'b1;
                w_r_in  = w_rx_hot;
                w_done  = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef BUS_SEQ_MVNZ_EN
    assign w_unused = ^r_ir[6:0];
`else
    assign w_unused = ^{r_ir[6:0], bus.g_zero};
`endif

    assign bus.imediate_select = w_imm_sel;
    assign bus.r0_select       = w_reg_sel[0];
    assign bus.r1_select       = w_reg_sel[1];
    assign bus.r2_select       = w_reg_sel[2];
    assign bus.r3_select       = w_reg_sel[3];
    assign bus.r4_select       = w_reg_sel[4];
    assign bus.r5_select       = w_reg_sel[5];
    assign bus.r6_select       = w_reg_sel[6];
    assign bus.r7_select       = w_reg_sel[7];
    assign bus.r_select        = w_g_sel;
    assign bus.r_in            = w_r_in;
    assign bus.a_in            = w_a_in;
    assign bus.g_in            = w_g_in;
    assign bus.alu_sub         = w_alu_sub;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.done            = w_done;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed vector table, hand-written corner sequences, and random instructions against a reference model.
// Define BUS_SEQ_MVNZ_EN for both bench and RTL to verify the mvnz build.
module tb_bus_sequencer;

    logic clock;
    logic reset;
    bus_sequencer_if bus ();

    bus_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Observed vector: {imm, rsel[7:0], g_sel, r_in[7:0], a_in, g_in, alu_sub, busy, done}
    typedef logic [22:0] obs_t;

    typedef struct packed {
        logic [15:0]     din;
        logic            gz;
        logic [1:0]      n;
        logic [2:0][22:0] exp;
    } vec_t;

    function automatic obs_t pk(bit imm, logic [7:0] rs, bit g, logic [7:0] ri,
                                bit a, bit gi, bit sub, bit bsy, bit dn);
        return {imm, rs, g, ri, a, gi, sub, bsy, dn};
    endfunction

    function automatic obs_t sample();
        return {bus.imediate_select,
                bus.r7_select, bus.r6_select, bus.r5_select, bus.r4_select,
                bus.r3_select, bus.r2_select, bus.r1_select, bus.r0_select,
                bus.r_select, bus.r_in, bus.a_in, bus.g_in, bus.alu_sub,
                bus.busy, bus.done};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: the number of execute cycles and the expected outputs in cycle k (1-based).
    function automatic int model_len(logic [15:0] ins);
        return (ins[15:13] == 3'b010 || ins[15:13] == 3'b011) ? 3 : 1;
    endfunction

    function automatic obs_t model(logic [15:0] ins, bit gz, int k);
        logic [2:0] op;
        logic [7:0] hx;
        logic [7:0] hy;
        op = ins[15:13];
        hx = 8'(1 << ins[12:10]);
        hy = 8'(1 << ins[9:7]);
        case (op)
            3'b000: return pk(0, hy, 0, hx, 0, 0, 0, 1, 1);
            3'b001: return pk(1, 8'h00, 0, hx, 0, 0, 0, 1, 1);
            3'b010, 3'b011: begin
                if (k == 1) return pk(0, hx, 0, 8'h00, 1, 0, 0, 1, 0);
                if (k == 2) return pk(0, hy, 0, 8'h00, 0, 1, op[0], 1, 0);
                return pk(0, 8'h00, 1, hx, 0, 0, 0, 1, 1);
            end
`ifdef BUS_SEQ_MVNZ_EN
            3'b100: return gz ? pk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1)
                              : pk(0, hy, 0, hx, 0, 0, 0, 1, 1);
`endif
            default: return pk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1);
        endcase
    endfunction

    // Issue one instruction from IDLE, check every execute cycle, then check the IDLE cycle that follows.
    task automatic run_instr(input string name, input logic [15:0] ins, input bit gz,
                             input int n, input logic [2:0][22:0] exp);
        bus.run    = 1'b1;
        bus.din    = ins;
        bus.g_zero = gz;
        step();
        bus.run = 1'b0;
        bus.din = $urandom();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s T%0d", name, k + 1), sample(), exp[k]);
            step();
        end
        check($sformatf("%s idle", name), sample(), 23'h0);
    endtask

    vec_t tbl[11];
    obs_t done_only;
    logic [2:0][22:0] ev;

    initial begin
        done_only = pk(0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1);

        tbl[0]  = '{din: 16'h0280, gz: 0, n: 1, exp: {23'h0, 23'h0, pk(0, 8'h20, 0, 8'h01, 0, 0, 0, 1, 1)}};
        tbl[1]  = '{din: 16'h2400, gz: 0, n: 1, exp: {23'h0, 23'h0, pk(1, 8'h00, 0, 8'h02, 0, 0, 0, 1, 1)}};
        tbl[2]  = '{din: 16'h4980, gz: 0, n: 3, exp: {pk(0, 8'h00, 1, 8'h04, 0, 0, 0, 1, 1),
                                                     pk(0, 8'h08, 0, 8'h00, 0, 1, 0, 1, 0),
                                                     pk(0, 8'h04, 0, 8'h00, 1, 0, 0, 1, 0)}};
        tbl[3]  = '{din: 16'h7F80, gz: 0, n: 3, exp: {pk(0, 8'h00, 1, 8'h80, 0, 0, 0, 1, 1),
                                                     pk(0, 8'h80, 0, 8'h00, 0, 1, 1, 1, 0),
                                                     pk(0, 8'h80, 0, 8'h00, 1, 0, 0, 1, 0)}};
        tbl[4]  = '{din: 16'h4D80, gz: 1, n: 3, exp: {pk(0, 8'h00, 1, 8'h08, 0, 0, 0, 1, 1),
                                                     pk(0, 8'h08, 0, 8'h00, 0, 1, 0, 1, 0),
                                                     pk(0, 8'h08, 0, 8'h00, 1, 0, 0, 1, 0)}};
        tbl[5]  = '{din: 16'h1C7F, gz: 0, n: 1, exp: {23'h0, 23'h0, pk(0, 8'h01, 0, 8'h80, 0, 0, 0, 1, 1)}};
`ifdef BUS_SEQ_MVNZ_EN
        tbl[6]  = '{din: 16'h9300, gz: 0, n: 1, exp: {23'h0, 23'h0, pk(0, 8'h40, 0, 8'h10, 0, 0, 0, 1, 1)}};
`else
        tbl[6]  = '{din: 16'h9300, gz: 0, n: 1, exp: {23'h0, 23'h0, done_only}};
`endif
        tbl[7]  = '{din: 16'h9300, gz: 1, n: 1, exp: {23'h0, 23'h0, done_only}};
        tbl[8]  = '{din: 16'hE000, gz: 0, n: 1, exp: {23'h0, 23'h0, done_only}};
        tbl[9]  = '{din: 16'hA000, gz: 0, n: 1, exp: {23'h0, 23'h0, done_only}};
        tbl[10] = '{din: 16'hFFFF, gz: 1, n: 1, exp: {23'h0, 23'h0, done_only}};

        bus.run    = 1'b0;
        bus.din    = 16'h0;
        bus.g_zero = 1'b0;
        reset      = 1'b1;
        #1;
        check("reset outputs", sample(), 23'h0);
        check("reset ir", 23'(dut.r_ir), 23'h0);
        step();
        step();
        #2 reset = 1'b0;
        step();
        check("idle after reset", sample(), 23'h0);

        for (int i = 0; i < 11; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i].din, tbl[i].gz, int'(tbl[i].n), tbl[i].exp);
        end

        // run held high through an add: it is ignored while busy, and the next instruction starts after T3.
        bus.run = 1'b1;
        bus.din = 16'h4980;
        step();
        bus.din = 16'h0280;
        check("hold T1", sample(), tbl[2].exp[0]);
        step();
        check("hold T2", sample(), tbl[2].exp[1]);
        step();
        check("hold T3", sample(), tbl[2].exp[2]);
        step();
        check("hold idle", sample(), 23'h0);
        step();
        bus.run = 1'b0;
        check("b2b mv T1", sample(), tbl[0].exp[0]);
        step();
        check("b2b idle", sample(), 23'h0);

        // Reset in the middle of T2 abandons the sub without producing done.
        bus.run = 1'b1;
        bus.din = 16'h7F80;
        step();
        bus.run = 1'b0;
        check("rst seq T1", sample(), tbl[3].exp[0]);
        step();
        check("rst seq T2", sample(), tbl[3].exp[1]);
        #2 reset = 1'b1;
        #1;
        check("mid reset outputs", sample(), 23'h0);
        check("mid reset ir", 23'(dut.r_ir), 23'h0);
        #3 reset = 1'b0;
        step();
        check("post reset idle", sample(), 23'h0);
        step();
        check("post reset idle2", sample(), 23'h0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins;
            bit gz;
            int n;
            ins = 16'($urandom());
            gz  = 1'($urandom_range(0, 1));
            n   = model_len(ins);
            ev  = '0;
            for (int k = 0; k < n; k++) ev[k] = model(ins, gz, k + 1);
            run_instr($sformatf("rand%0d %04h", i, ins), ins, gz, n, ev);
            if ($urandom_range(0, 3) == 0) begin
                step();
                check($sformatf("rand%0d gap", i), sample(), 23'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
